sd_cmd_responder: RTL and testbench

Card-side responder for the SD CMD line: the far end of the host SD command path. It oversamples the external SD clock and CMD pin in the msoc_clk domain and receives 48-bit host commands, checking their CRC7. It hands each command to card-model logic over a valid/ready handshake, then serialises the R1, R2 or R3 response that logic supplies. It serves FPGA loopback and self-test of the host controller, without a physical card.

---
 rtl/sd_resp_pkg.sv | 24 ++
 rtl/sd_crc7.sv | 27 ++
 rtl/sd_cmd_responder.sv | 208 ++++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the card-side SD CMD responder.
package sd_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    REPORT,
    WAIT_RESP,
    GAP,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_e;

  localparam logic [6:0] CRC7_POLY       = 7'h09;
  localparam int         FRAME_LEN_SHORT = 48;
  localparam int         FRAME_LEN_LONG  = 136;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, initial value zero.
module sd_crc7 (
  input  logic       msoc_clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_val,
  output logic [6:0] crc
);
  import sd_resp_pkg::*;

  logic feedback;

  assign feedback = bit_val ^ crc[6];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: oversamples sd_sclk/CMD, receives 48-bit
// commands, hands them off, then serialises an R1/R2/R3 response.
module sd_cmd_responder #(
  parameter int NCR_MIN      = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         msoc_clk,
  input  logic         rstn,
  input  logic         sd_sclk,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_ok,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   resp_index,
  input  logic [119:0] resp_data,
  output logic         busy,
  output logic         timeout_evt
);
  import sd_resp_pkg::*;

  localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

  state_e             state, next_state;
  logic [2:0]         sclk_sync;
  logic [1:0]         cmd_sync;
  logic               rise, fall, cmd_bit, last_bit;
  logic [7:0]         bit_cnt, gap_cnt, tx_cnt;
  logic [44:0]        rx_shift;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [135:0]       tx_shift;
  resp_type_e         tx_type;
  logic [6:0]         rx_crc, tx_crc;
  logic               rx_crc_clear, rx_crc_en, tx_crc_clear, tx_crc_en;
  logic [7:0]         tx_len, crc_lo, crc_hi;
  logic [2:0]         crc_off;
  logic               has_crc, in_crc_feed, in_crc_out, tx_bit;

  // sclk gets a third stage so edges are detected on synchronised samples.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= 3'b000;
      cmd_sync  <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sd_sclk};
      cmd_sync  <= {cmd_sync[0], cmd_in};
    end
  end

  assign rise    = sclk_sync[1] & ~sclk_sync[2];
  assign fall    = ~sclk_sync[1] & sclk_sync[2];
  assign cmd_bit = cmd_sync[1];

  sd_crc7 u_rx_crc (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .clear    (rx_crc_clear),
    .enable   (rx_crc_en),
    .bit_val  (cmd_bit),
    .crc      (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .clear    (tx_crc_clear),
    .enable   (tx_crc_en),
    .bit_val  (tx_shift[135]),
    .crc      (tx_crc)
  );

  // Frame geometry: CRC covers [crc_lo, crc_hi), then 7 CRC bits, then the end bit.
  always_comb begin
    tx_len      = (tx_type == RESP_R2) ? 8'(FRAME_LEN_LONG) : 8'(FRAME_LEN_SHORT);
    crc_lo      = (tx_type == RESP_R2) ? 8'd8 : 8'd0;
    crc_hi      = tx_len - 8'd8;
    has_crc     = (tx_type != RESP_R3);
    in_crc_feed = has_crc && (tx_cnt >= crc_lo) && (tx_cnt < crc_hi);
    in_crc_out  = has_crc && (tx_cnt >= crc_hi) && (tx_cnt < tx_len - 8'd1);
    crc_off     = 3'(crc_hi + 8'd6 - tx_cnt);
    tx_bit      = in_crc_out ? tx_crc[crc_off] : tx_shift[135];
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block is defaulted first so no latch can be inferred.
  always_comb begin
    next_state   = state;
    cmd_valid    = 1'b0;
    resp_ready   = 1'b0;
    timeout_evt  = 1'b0;
    rx_crc_clear = 1'b0;
    rx_crc_en    = 1'b0;
    tx_crc_clear = 1'b0;
    tx_crc_en    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: if (rise) begin
        // A sampled 0 is the start bit; clearing matches feeding a 0 into a zero CRC.
        if (!cmd_bit) begin
          rx_crc_clear = 1'b1;
        end else if (!last_bit) begin
          rx_crc_en  = 1'b1;
          next_state = RECV;
        end
      end
      RECV: if (rise) begin
        rx_crc_en = (bit_cnt < 8'd38);
        if (bit_cnt == 8'd45) next_state = REPORT;
      end
      REPORT: begin
        cmd_valid = 1'b1;
        if (cmd_ready) next_state = WAIT_RESP;
      end
      WAIT_RESP: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          tx_crc_clear = 1'b1;
          next_state   = (resp_type_e'(resp_type) == RESP_NONE) ? IDLE : GAP;
        end else if (rise && tmo_cnt == TMO_W'(RESP_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          next_state  = IDLE;
        end
      end
      GAP: if (gap_cnt >= 8'(NCR_MIN)) next_state = SEND;
      SEND: if (fall) begin
        if (tx_cnt == tx_len) next_state = IDLE;
        else                  tx_crc_en  = in_crc_feed;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      last_bit   <= 1'b1;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
      cmd_crc_ok <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      tx_shift   <= '0;
      tx_type    <= RESP_NONE;
      tx_cnt     <= '0;
      cmd_out    <= 1'b1;
      cmd_oe     <= 1'b0;
    end else begin
      if (state != IDLE) last_bit <= 1'b1;
      else if (rise)     last_bit <= cmd_bit;

      // Ncr is measured in falling edges from the end-bit sample onward.
      if (fall && gap_cnt != 8'hff && (state == REPORT || state == WAIT_RESP || state == GAP))
        gap_cnt <= gap_cnt + 8'd1;

      case (state)
        IDLE: bit_cnt <= '0;
        RECV: if (rise) begin
          rx_shift <= {rx_shift[43:0], cmd_bit};
          bit_cnt  <= bit_cnt + 8'd1;
          if (bit_cnt == 8'd45) begin
            cmd_index  <= rx_shift[44:39];
            cmd_arg    <= rx_shift[38:7];
            cmd_crc_ok <= (rx_shift[6:0] == rx_crc) && cmd_bit;
            gap_cnt    <= '0;
          end
        end
        REPORT: tmo_cnt <= '0;
        WAIT_RESP: begin
          if (resp_valid) begin
            tx_type <= resp_type_e'(resp_type);
            tx_cnt  <= '0;
            case (resp_type_e'(resp_type))
              RESP_R2: tx_shift <= {2'b00, 6'h3f, resp_data, 8'hff};
              RESP_R3: tx_shift <= {2'b00, 6'h3f, resp_data[31:0], 8'hff, 88'd0};
              default: tx_shift <= {2'b00, resp_index, resp_data[31:0], 8'hff, 88'd0};
            endcase
          end else if (rise && tmo_cnt != TMO_W'(RESP_TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND: if (fall) begin
          if (tx_cnt == tx_len) begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
          end else begin
            cmd_oe   <= 1'b1;
            cmd_out  <= tx_bit;
            tx_shift <= {tx_shift[134:0], 1'b0};
            tx_cnt   <= tx_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed self-checking bench: acts as SD host driving CMD and as card-model logic.
module tb_sd_cmd_responder;

  logic         msoc_clk, rstn, sd_sclk, cmd_in;
  logic         cmd_out, cmd_oe, cmd_valid, cmd_ready, cmd_crc_ok;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         resp_valid, resp_ready, busy, timeout_evt;
  logic [1:0]   resp_type;
  logic [5:0]   resp_index;
  logic [119:0] resp_data;

  int checks, errors, sclk_rises;
  int lead, oe_cnt, pulses, oe_seen, r0, r_at, n;
  logic [135:0] frame;

  sd_cmd_responder #(.NCR_MIN(2), .RESP_TIMEOUT(64)) dut (
    .msoc_clk    (msoc_clk),
    .rstn        (rstn),
    .sd_sclk     (sd_sclk),
    .cmd_in      (cmd_in),
    .cmd_out     (cmd_out),
    .cmd_oe      (cmd_oe),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_crc_ok  (cmd_crc_ok),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_type   (resp_type),
    .resp_index  (resp_index),
    .resp_data   (resp_data),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial begin
    msoc_clk = 1'b0;
    forever #5 msoc_clk = ~msoc_clk;
  end

  initial begin
    sd_sclk = 1'b0;
    forever #80 sd_sclk = ~sd_sclk;
  end

  always @(posedge sd_sclk) sclk_rises++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    logic [6:0]  c;
    logic        fb;
    m = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Host drives CMD on falling sclk; returns after releasing the line one bit after the end bit.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                          input logic end_bit);
    logic [47:0] f;
    int w;
    f = {2'b01, idx, arg, crc, end_bit};
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_sclk);
      cmd_in = f[i];
    end
    @(posedge sd_sclk);
    w = 0;
    while (!cmd_valid && w < 8) begin
      @(negedge msoc_clk);
      w++;
    end
    check("cmd_valid_rise", 136'(cmd_valid), 136'(1));
    @(negedge sd_sclk);
    cmd_in = 1'b1;
  endtask

  task automatic accept_cmd();
    @(negedge msoc_clk);
    cmd_ready = 1'b1;
    @(negedge msoc_clk);
    cmd_ready = 1'b0;
    check("cmd_valid_drop", 136'(cmd_valid), 136'(0));
    check("resp_ready_up", 136'(resp_ready), 136'(1));
  endtask

  task automatic give_resp(input logic [1:0] t, input logic [5:0] idx, input logic [119:0] d);
    @(negedge msoc_clk);
    resp_type  = t;
    resp_index = idx;
    resp_data  = d;
    resp_valid = 1'b1;
    @(negedge msoc_clk);
    resp_valid = 1'b0;
    check("resp_ready_drop", 136'(resp_ready), 136'(0));
  endtask

  // Samples cmd_out on rising sclk; lead = rising edges until cmd_oe first seen.
  task automatic capture(input int nbits, output logic [135:0] data, output int ld, output int oec);
    data = '0;
    ld   = 0;
    oec  = 0;
    do begin
      @(posedge sd_sclk);
      ld++;
    end while (!cmd_oe && ld < 20);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) @(posedge sd_sclk);
      data = {data[134:0], cmd_out};
      if (cmd_oe) oec++;
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge sd_sclk);
      if (cmd_oe) oec++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; sclk_rises = 0;
    rstn = 1'b0; cmd_in = 1'b1; cmd_ready = 1'b0; resp_valid = 1'b0;
    resp_type = 2'd0; resp_index = '0; resp_data = '0;
    repeat (4) @(negedge msoc_clk);
    check("rst_cmd_out", 136'(cmd_out), 136'(1));
    check("rst_cmd_oe", 136'(cmd_oe), 136'(0));
    check("rst_cmd_valid", 136'(cmd_valid), 136'(0));
    check("rst_resp_ready", 136'(resp_ready), 136'(0));
    check("rst_busy", 136'(busy), 136'(0));
    check("rst_timeout", 136'(timeout_evt), 136'(0));
    check("rst_index_arg", 136'({cmd_index, cmd_arg}), 136'(0));
    check("rst_crc_ok", 136'(cmd_crc_ok), 136'(0));
    rstn = 1'b1;
    repeat (4) @(posedge sd_sclk);

    // CMD0, no response
    send_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
    check("cmd0_index", 136'(cmd_index), 136'(0));
    check("cmd0_arg", 136'(cmd_arg), 136'(0));
    check("cmd0_crc_ok", 136'(cmd_crc_ok), 136'(1));
    check("cmd0_busy", 136'(busy), 136'(1));
    accept_cmd();
    give_resp(2'd0, 6'd0, '0);
    check("cmd0_idle", 136'(busy), 136'(0));

    // CMD8 answered with R1
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
    check("cmd8_index", 136'(cmd_index), 136'(8));
    check("cmd8_arg", 136'(cmd_arg), 136'(32'h1AA));
    check("cmd8_crc_ok", 136'(cmd_crc_ok), 136'(1));
    accept_cmd();
    give_resp(2'd1, 6'd8, 120'h1AA);
    capture(48, frame, lead, oe_cnt);
    check("r1_lead", 136'(lead), 136'(3));
    check("r1_frame", frame, 136'(48'h08_0000_01AA_13));
    check("r1_oe_len", 136'(oe_cnt), 136'(48));
    check("r1_idle", 136'(busy), 136'(0));

    // CMD17 with corrupted CRC, then response timeout
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd17, 32'h0000_0200, 7'h00, 1'b1);
    check("cmd17_index", 136'(cmd_index), 136'(17));
    check("cmd17_crc_bad", 136'(cmd_crc_ok), 136'(0));
    accept_cmd();
    r0 = sclk_rises; pulses = 0; oe_seen = 0; r_at = 0;
    for (int c = 0; c < 1400; c++) begin
      @(negedge msoc_clk);
      if (timeout_evt) begin
        pulses++;
        r_at = sclk_rises - r0;
      end
      if (cmd_oe) oe_seen = 1;
    end
    check("tmo_pulses", 136'(pulses), 136'(1));
    check("tmo_rises", 136'(r_at), 136'(64));
    check("tmo_no_oe", 136'(oe_seen), 136'(0));
    check("tmo_idle", 136'(busy), 136'(0));

    // end bit 0: reported, crc_ok forced low
    send_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    check("endbit0_crc_ok", 136'(cmd_crc_ok), 136'(0));
    accept_cmd();
    give_resp(2'd0, 6'd0, '0);

    // CMD2 answered with R2
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd2, 32'h0, crc7_cmd(6'd2, 32'h0), 1'b1);
    check("cmd2_crc_ok", 136'(cmd_crc_ok), 136'(1));
    accept_cmd();
    give_resp(2'd2, 6'd0, 120'h5A);
    capture(136, frame, lead, oe_cnt);
    check("r2_lead", 136'(lead), 136'(3));
    check("r2_frame", frame, {8'h3F, 112'h0, 8'h5A, 8'h4F});
    check("r2_oe_len", 136'(oe_cnt), 136'(136));

    // ACMD41 answered with R3
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd41, 32'h40FF_8000, crc7_cmd(6'd41, 32'h40FF_8000), 1'b1);
    check("cmd41_index", 136'(cmd_index), 136'(41));
    accept_cmd();
    give_resp(2'd3, 6'd41, 120'h80FF_8000);
    capture(48, frame, lead, oe_cnt);
    check("r3_frame", frame, 136'(48'h3F_80FF_8000_FF));
    check("r3_oe_len", 136'(oe_cnt), 136'(48));

    // reset in the middle of SEND
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
    accept_cmd();
    give_resp(2'd1, 6'd8, 120'h1AA);
    n = 0;
    while (!cmd_oe && n < 400) begin
      @(negedge msoc_clk);
      n++;
    end
    repeat (10) @(posedge sd_sclk);
    check("midsend_oe", 136'(cmd_oe), 136'(1));
    #3 rstn = 1'b0;
    #1;
    check("midrst_oe", 136'(cmd_oe), 136'(0));
    check("midrst_out", 136'(cmd_out), 136'(1));
    check("midrst_busy", 136'(busy), 136'(0));
    repeat (3) @(negedge msoc_clk);
    rstn = 1'b1;
    repeat (2) @(posedge sd_sclk);
    send_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
    check("post_rst_index", 136'(cmd_index), 136'(0));
    check("post_rst_crc_ok", 136'(cmd_crc_ok), 136'(1));
    accept_cmd();
    give_resp(2'd0, 6'd0, '0);
    check("post_rst_idle", 136'(busy), 136'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
